// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl
// Computes an 8x8 unsigned product by time-sharing one 4x4 approximate
// sub-multiplier over four partial-product cycles (LL, LH, HL, HH).
// Each cycle carries its own mode code, so the shared sub-multiplier applies
// the same per-quadrant approximation mix as the parallel multipliers.
// The four partial products are shift-added into a 17-bit accumulator.
// R saturates to 16'hFFFF if that accumulator overflows 16 bits.
//
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN.
// When it is defined, an operand pair with A == 0 or B == 0 goes straight
// to DONE with R = 0 and skips the PP cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// PP0   | A[3:0] x B[3:0], mode MODE_LL, adds lm_r << 0
// PP1   | A[3:0] x B[7:4], mode MODE_LH, adds lm_r << 4
// PP2   | A[7:4] x B[3:0], mode MODE_HL, adds lm_r << 4
// PP3   | A[7:4] x B[7:4], mode MODE_HH, adds lm_r << 8, loads R
// DONE  | R valid; held until out_ready, back-to-back accept allowed
module approx_mult_seq_ctrl #(
  parameter logic [1:0] MODE_LL = 2'd3,
  parameter logic [1:0] MODE_LH = 2'd2,
  parameter logic [1:0] MODE_HL = 2'd1,
  parameter logic [1:0] MODE_HH = 2'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [3:0]  lm_a,
  output logic [3:0]  lm_b,
  output logic [1:0]  lm_mode,
  input  logic [7:0]  lm_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [16:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic [16:0] pp_shifted;
  logic [16:0] acc_sum;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == PP0) || (state_q == PP1) ||
                     (state_q == PP2) || (state_q == PP3);
  assign R         = r_q;
  assign acc_sum   = acc_q + pp_shifted;

  // Sub-multiplier operands and mode come only from registered operands and state.
  always_comb begin
    lm_a       = 4'd0;
    lm_b       = 4'd0;
    lm_mode    = 2'd0;
    pp_shifted = 17'd0;
    case (state_q)
      PP0: begin
        lm_a = a_q[3:0]; lm_b = b_q[3:0]; lm_mode = MODE_LL;
        pp_shifted = {9'd0, lm_r};
      end
      PP1: begin
        lm_a = a_q[3:0]; lm_b = b_q[7:4]; lm_mode = MODE_LH;
        pp_shifted = {5'd0, lm_r, 4'd0};
      end
      PP2: begin
        lm_a = a_q[7:4]; lm_b = b_q[3:0]; lm_mode = MODE_HL;
        pp_shifted = {5'd0, lm_r, 4'd0};
      end
      PP3: begin
        lm_a = a_q[7:4]; lm_b = b_q[7:4]; lm_mode = MODE_HH;
        pp_shifted = {1'b0, lm_r, 8'd0};
      end
      default: ;
    endcase
  end

  // Next state, operand capture, accumulation and result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    if (in_valid && in_ready) begin
      // Accept from IDLE, or back-to-back from DONE with out_ready.
      a_d     = A;
      b_d     = B;
      acc_d   = 17'd0;
      state_d = PP0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      if ((A == 8'd0) || (B == 8'd0)) begin
        state_d = DONE;
        r_d     = 16'd0;
      end
`endif
    end else begin
      case (state_q)
        PP0: begin acc_d = acc_sum; state_d = PP1; end
        PP1: begin acc_d = acc_sum; state_d = PP2; end
        PP2: begin acc_d = acc_sum; state_d = PP3; end
        PP3: begin
          acc_d   = acc_sum;
          r_d     = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
          state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 17'd0;
      r_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Directed testbench for approx_mult_seq_ctrl.
// The sub-multiplier is modelled in the bench: exact nibble product, or a
// constant 8'hFF while sat_model is set.
module tb_approx_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  A = 8'd0;
  logic [7:0]  B = 8'd0;
  logic [3:0]  lm_a;
  logic [3:0]  lm_b;
  logic [1:0]  lm_mode;
  logic [7:0]  lm_r;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] R;
  logic        busy;
  logic        sat_model = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign lm_r = sat_model ? 8'hFF : ({4'd0, lm_a} * {4'd0, lm_b});

  approx_mult_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .lm_a(lm_a), .lm_b(lm_b), .lm_mode(lm_mode), .lm_r(lm_r),
    .out_valid(out_valid), .out_ready(out_ready), .R(R), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_mode [4];
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_mode = '{2'd3, 2'd2, 2'd1, 2'd1};
    exp_a    = '{4'hF, 4'hF, 4'hF, 4'hF};
    exp_b    = '{4'hF, 4'hF, 4'hF, 4'hF};
    rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (R !== 16'd0) begin errors++; $display("FAIL reset_R got=%0d exp=0", R); end
    checks++; if (lm_mode !== 2'd0 || lm_a !== 4'd0 || lm_b !== 4'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_lm got mode=%0d a=%0h b=%0h busy=%b exp all 0", lm_mode, lm_a, lm_b, busy); end
    step();
    rst_n = 1'b1;
    step();
    A = 8'hFF; B = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lm_mode !== exp_mode[i] || lm_a !== exp_a[i] || lm_b !== exp_b[i] ||
          busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ffxff_pp%0d got mode=%0d a=%0h b=%0h busy=%b ov=%b ir=%b exp mode=%0d a=%0h b=%0h busy=1 ov=0 ir=0",
                 i, lm_mode, lm_a, lm_b, busy, out_valid, in_ready, exp_mode[i], exp_a[i], exp_b[i]);
      end
      step();
    end
    checks++; if (out_valid !== 1'b1 || R !== 16'd65025 || busy !== 1'b0)
      begin errors++; $display("FAIL ffxff_done got ov=%b R=%0d busy=%b exp ov=1 R=65025 busy=0", out_valid, R, busy); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL ffxff_idle got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    A = 8'd200; B = 8'd13; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (out_valid !== 1'b1 || R !== 16'd2600)
      begin errors++; $display("FAIL bp_done got ov=%b R=%0d exp ov=1 R=2600", out_valid, R); end
    A = 8'd1; B = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || R !== 16'd2600 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b R=%0d ir=%b busy=%b exp ov=1 R=2600 ir=0 busy=0", i, out_valid, R, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_after got ov=%b busy=%b exp ov=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    A = 8'd12; B = 8'd34; in_valid = 1'b1;
    step();
    A = 8'd7; B = 8'd9;
    repeat (4) step();
    checks++; if (out_valid !== 1'b1 || R !== 16'd408 || in_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_first got ov=%b R=%0d ir=%b exp ov=1 R=408 ir=1", out_valid, R, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || lm_mode !== 2'd3 || lm_a !== 4'd7 || lm_b !== 4'd9)
      begin errors++; $display("FAIL b2b_accept got ov=%b busy=%b mode=%0d a=%0d b=%0d exp ov=0 busy=1 mode=3 a=7 b=9", out_valid, busy, lm_mode, lm_a, lm_b); end
    repeat (3) step();
    checks++; if (out_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_early got ov=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || R !== 16'd63)
      begin errors++; $display("FAIL b2b_second got ov=%b R=%0d exp ov=1 R=63", out_valid, R); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    A = 8'd99; B = 8'd77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    checks++; if (lm_mode !== 2'd1 || lm_a !== 4'd6 || lm_b !== 4'hD)
      begin errors++; $display("FAIL mid_pp2 got mode=%0d a=%0h b=%0h exp mode=1 a=6 b=d", lm_mode, lm_a, lm_b); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || R !== 16'd0 ||
                  lm_a !== 4'd0 || lm_b !== 4'd0 || lm_mode !== 2'd0)
      begin errors++; $display("FAIL mid_reset got busy=%b ir=%b ov=%b R=%0d a=%0h b=%0h mode=%0d exp 0 1 0 0 0 0 0",
                               busy, in_ready, out_valid, R, lm_a, lm_b, lm_mode); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b0)
        begin errors++; $display("FAIL mid_no_output%0d got ov=%b exp=0", i, out_valid); end
    end
    A = 8'd3; B = 8'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (out_valid !== 1'b1 || R !== 16'd15)
      begin errors++; $display("FAIL mid_next got ov=%b R=%0d exp ov=1 R=15", out_valid, R); end
    step();
  endtask

  task automatic test_saturation();
    sat_model = 1'b1;
    out_ready = 1'b1;
    A = 8'h12; B = 8'h34; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (out_valid !== 1'b1 || R !== 16'hFFFF)
      begin errors++; $display("FAIL sat got ov=%b R=%0h exp ov=1 R=ffff", out_valid, R); end
    step();
    sat_model = 1'b0;
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    A = 8'd0; B = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    checks++; if (out_valid !== 1'b1 || R !== 16'd0 || lm_a !== 4'd0 || lm_b !== 4'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL zero_skip got ov=%b R=%0d a=%0h b=%0h busy=%b exp ov=1 R=0 a=0 b=0 busy=0",
                               out_valid, R, lm_a, lm_b, busy); end
`else
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || lm_a !== 4'd0)
        begin errors++; $display("FAIL zero_pp%0d got busy=%b ov=%b a=%0h exp busy=1 ov=0 a=0", i, busy, out_valid, lm_a); end
      step();
    end
    checks++; if (out_valid !== 1'b1 || R !== 16'd0)
      begin errors++; $display("FAIL zero_done got ov=%b R=%0d exp ov=1 R=0", out_valid, R); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_mult_seq_ctrl.md
Name: approx_mult_seq_ctrl

Overview:
- Sequential controller that computes an 8x8 unsigned product by time-sharing one 4x4 approximate sub-multiplier over four partial-product cycles (LL, LH, HL, HH).
- Shift-adds the four partial products into a 16-bit result.
- Issues a per-cycle mode code so the shared sub-multiplier applies the same per-quadrant approximation mix as the parallel 8x8 multipliers, at roughly 1/4 of the LUT cost.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.

Parameters:
- MODE_LL, 3, mode code driven on lm_mode during the A[3:0] x B[3:0] cycle
- MODE_LH, 2, mode code for the A[3:0] x B[7:4] cycle
- MODE_HL, 1, mode code for the A[7:4] x B[3:0] cycle
- MODE_HH, 1, mode code for the A[7:4] x B[7:4] cycle

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- A  in  8  multiplicand
- B  in  8  multiplier
- lm_a  out  4  nibble of A to the shared sub-multiplier
- lm_b  out  4  nibble of B to the shared sub-multiplier
- lm_mode  out  2  approximation mode for the current cycle (0 = exact)
- lm_r  in  8  combinational product returned by the sub-multiplier
- out_valid  out  1  R valid
- out_ready  in  1  sink accepts R
- R  out  16  product
- busy  out  1  high in any PPx state

Behaviour:
- Reset: reset is asynchronous and active-low; rst_n low forces the following immediately, regardless of clk:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - R = 0, accumulator = 0
  - lm_a = 0, lm_b = 0, lm_mode = 0
- Reset mid-operation: asserting rst_n in any state discards the in-flight operation; no out_valid is produced for it.
- FSM states and transitions:
  - IDLE -> PP0 on in_valid && in_ready. A and B are latched; the accumulator is cleared.
  - PP0 -> PP1 -> PP2 -> PP3 -> DONE, unconditionally, one cycle each.
  - DONE -> IDLE when out_ready && !in_valid.
  - DONE -> PP0 when out_ready && in_valid. This is a back-to-back accept: new operands are latched and the accumulator is cleared.
  - DONE holds while !out_ready.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Partial-product cycles. lm_a, lm_b and lm_mode are driven from registered operands and state (no combinational path from A/B):
  - PP0: Areg[3:0], Breg[3:0], MODE_LL; adds lm_r << 0
  - PP1: Areg[3:0], Breg[7:4], MODE_LH; adds lm_r << 4
  - PP2: Areg[7:4], Breg[3:0], MODE_HL; adds lm_r << 4
  - PP3: Areg[7:4], Breg[7:4], MODE_HH; adds lm_r << 8
  - Outside PPx states: lm_a = lm_b = 0 and lm_mode = 0.
- Accumulation arithmetic:
  - lm_r is sampled at the rising edge that ends each PP cycle and added into a 17-bit accumulator, exact addition.
  - On the transition into DONE, R is loaded with acc[15:0], or 16'hFFFF if acc[16] = 1 (saturation; reachable only with approximate lm_r > 225).
- Output timing:
  - Latency: operands accepted at edge E0 give out_valid = 1 after edge E4.
  - out_valid = 1 only in DONE. R is stable while out_valid && !out_ready.
  - Throughput: one result per 5 cycles with out_ready held high (the back-to-back path saves the IDLE cycle).
- Operands on A/B while in_ready = 0 are ignored.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN.
- Defined: at acceptance, if A == 0 or B == 0, go directly IDLE -> DONE with R = 0, skipping PP0-PP3 (out_valid after 1 edge, lm_* stay 0). Non-zero operands behave exactly as without the macro.
- Undefined: all operands take the full four PP cycles.

Test Plan:
- Bench sub-multiplier model for scenarios 1-4: exact, lm_r = lm_a*lm_b.
- 1. Reset/idle: rst_n low -> in_ready=1, out_valid=0, R=0, lm_mode=0. Apply A=8'hFF, B=8'hFF, out_ready=1 -> out_valid after edge E4 with R=16'd65025; lm_mode trace 3,2,1,1 on PP0..PP3.
- 2. Backpressure: A=8'd200, B=8'd13, out_ready=0 for 6 cycles -> R=16'd2600 held stable with out_valid=1, in_ready=0, and new in_valid ignored; releasing out_ready completes the transfer.
- 3. Back-to-back: in_valid held with A=12/B=34, then A=7/B=9 -> results 408 then 63; second accept occurs in the DONE cycle; results spaced 5 cycles apart.
- 4. Reset mid-op: assert rst_n low during PP2 of A=99, B=77 -> outputs reset immediately, no out_valid; next op A=3, B=5 gives R=15.
- 5. Saturation (model lm_r = 8'hFF always): any operands -> acc = 255 + 4080 + 4080 + 65280 = 73695 > 65535 -> R=16'hFFFF.
- 6. Zero skip with MULT_SEQ_ZERO_SKIP_EN: A=0, B=8'h5A -> out_valid after 1 edge, R=0, lm_a/lm_b never toggle. Without the macro: 4 PP cycles, R=0.
